// File: rtl/uart_stim_tx.sv
// Bench-side UART transmitter: a byte FIFO feeding an 8N1 serialiser at CLKS_PER_BIT clocks per bit.
// Define UART_STIM_PARITY_EN to insert a parity bit (even or odd, chosen by PARITY_ODD) after the data bits.
module uart_stim_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               tx_o,
    output logic               busy_o,
    output logic               tx_done_o,
    output logic [FIFO_AW:0]   fifo_level_o
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int LVL_W = FIFO_AW + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

`ifdef UART_STIM_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d, bit_inc;
    logic [7:0]         byte_q, byte_d;
    logic               tx_q, tx_d;
    logic               push, pop, bit_end, fifo_nempty;

    assign ready_o     = (level_q != LVL_FULL);
    assign push        = valid_i & ready_o;
    assign fifo_nempty = (level_q != '0);
    assign level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    assign bit_end     = (cnt_q == CNT_MAX);
    assign bit_inc     = bit_q + 3'd1;

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_q + FIFO_AW'(push);
            rd_ptr_q <= rd_ptr_q + FIFO_AW'(pop);
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    byte_d  = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = byte_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_STIM_PARITY_EN
                        state_d = PARITY;
                        tx_d    = (PARITY_ODD != 0) ? ~^byte_q : ^byte_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_inc;
                        tx_d  = byte_q[bit_inc];
                    end
                end
            end
`ifdef UART_STIM_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        byte_d  = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o         = tx_q;
    assign tx_done_o    = (state_q == STOP) & bit_end;
    assign busy_o       = (state_q != IDLE) | fifo_nempty;
    assign fifo_level_o = level_q;

endmodule
